ram_arbiter: RTL

Two-requester arbiter that shares the single-port data RAM between the core load/store path (port 0) and a secondary master such as a program loader or debug/DMA engine (port 1). It sits between the core/secondary master and the RAM's write_enable/read_enable/addr/din/dout pins. Each cycle it grants at most one access using weighted round-robin, and it routes read data back to the port that issued the read. A port that requests but is not granted stalls until it is granted.

---
 rtl/ram_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Weighted round-robin arbiter sharing one single-port RAM between two masters.
// Port 0 wins after any port-1 grant streak of P1_BURST under contention.
module ram_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned P1_BURST = 4
) (
    input  logic              CLOCK,
    input  logic              RST,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [3:0] BURST = 4'(P1_BURST);

    logic       prio_q, prio_d;
    logic [3:0] bcnt_q, bcnt_d;
    logic       rsel_q, rsel_d;
    logic       rpend_q, rpend_d;
    logic [3:0] bcnt_inc;
    logic       rvalid;

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            prio_q  <= 1'b0;
            bcnt_q  <= '0;
            rsel_q  <= 1'b0;
            rpend_q <= 1'b0;
        end else begin
            prio_q  <= prio_d;
            bcnt_q  <= bcnt_d;
            rsel_q  <= rsel_d;
            rpend_q <= rpend_d;
        end
    end

    // Grants are suppressed during reset so no RAM access is issued.
    always_comb begin
        gnt0     = ~RST & req0 & (~req1 | ~prio_q);
        gnt1     = ~RST & req1 & (~req0 |  prio_q);
        bcnt_inc = bcnt_q + 4'd1;
        prio_d   = prio_q;
        bcnt_d   = bcnt_q;
        rsel_d   = rsel_q;
        rpend_d  = (gnt0 & ~we0) | (gnt1 & ~we1);
        if (gnt0) begin
            prio_d = 1'b1;
            bcnt_d = '0;
            rsel_d = 1'b0;
        end else if (gnt1) begin
            rsel_d = 1'b1;
            if (bcnt_inc == BURST) begin
                prio_d = 1'b0;
                bcnt_d = '0;
            end else begin
                prio_d = 1'b1;
                bcnt_d = bcnt_inc;
            end
        end
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (gnt0) begin
            ram_we   = we0;
            ram_re   = ~we0;
            ram_addr = addr0;
            ram_din  = wdata0;
        end else if (gnt1) begin
            ram_we   = we1;
            ram_re   = ~we1;
            ram_addr = addr1;
            ram_din  = wdata1;
        end
        // A read in flight when reset arrives is dropped, not returned.
        rvalid  = rpend_q & ~RST;
        rvalid0 = rvalid & ~rsel_q;
        rvalid1 = rvalid &  rsel_q;
        rdata0  = rvalid0 ? ram_dout : '0;
        rdata1  = rvalid1 ? ram_dout : '0;
    end

endmodule
